// File: rtl/fetch_unit_pkg.sv
// Shared types and constants for the instruction fetch unit.
// Build option FETCH_PREFETCH_BUF_EN (see fetch_unit.sv) does not change anything here.
package fetch_unit_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    RUN      = 2'd1,
    REDIRECT = 2'd2
  } fetch_state_e;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_entry_t;

  localparam logic [31:0] PC_STEP = 32'd4;

  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_unit_buffer.sv
// fetch_buffer: shift-style instruction FIFO with push/pop/clear and occupancy count.
// Depth is 2 with FETCH_PREFETCH_BUF_EN defined, otherwise a single register.
module fetch_buffer
  import fetch_unit_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  input  logic         push_i,
  input  logic         pop_i,
  input  logic         clear_i,
  input  fetch_entry_t data_i,
  output fetch_entry_t head_o,
  output logic [1:0]   count_o
);

`ifdef FETCH_PREFETCH_BUF_EN
  localparam int DEPTH = 2;
`else
  localparam int DEPTH = 1;
`endif

  fetch_entry_t mem_q [DEPTH];
  fetch_entry_t mem_d [DEPTH];
  logic [1:0]   count_q;
  logic [1:0]   count_d;
  logic [1:0]   wr_idx_s;

  // Next-state: a pop shifts entries toward the head, a push lands behind the survivors.
  always_comb begin
    mem_d    = mem_q;
    count_d  = count_q;
    wr_idx_s = count_q;
    if (clear_i) begin
      count_d = 2'd0;
    end else begin
      if (pop_i) begin
        for (int i = 0; i < DEPTH - 1; i++) begin
          mem_d[i] = mem_q[i+1];
        end
        wr_idx_s = count_q - 2'd1;
      end else begin
        wr_idx_s = count_q;
      end
      for (int i = 0; i < DEPTH; i++) begin
        if (push_i && (wr_idx_s == 2'(i))) begin
          mem_d[i] = data_i;
        end else begin
          mem_d[i] = mem_d[i];
        end
      end
      count_d = count_q + {1'b0, push_i} - {1'b0, pop_i};
    end
  end

  // Storage registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= 2'd0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      count_q <= count_d;
      mem_q   <= mem_d;
    end
  end

  // Stale data is masked so an empty buffer presents zeros.
  assign head_o  = (count_q != 2'd0) ? mem_q[0] : '0;
  assign count_o = count_q;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch front end: IDLE/RUN/REDIRECT sequencer plus fetch PC feeding fetch_buffer.
// FETCH_PREFETCH_BUF_EN enables a 2-entry prefetch buffer; the default is a single register.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        hazard,
  input  logic        branch_taken,
  input  logic [31:0] branch_addr,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic        valid,
  output logic [31:0] instruction,
  output logic [31:0] PC_out
);

  fetch_state_e state_q;
  logic [31:0]  fetch_pc_q;
  fetch_entry_t head_s;
  fetch_entry_t push_data_s;
  logic [1:0]   count_s;
  logic         valid_s;
  logic         pop_s;
  logic         space_s;
  logic         req_s;
  logic         xfer_s;
  logic         push_s;

  assign valid_s = (count_s != 2'd0);
  assign pop_s   = valid_s & ~hazard;

`ifdef FETCH_PREFETCH_BUF_EN
  assign space_s = (count_s < 2'd2);
`else
  assign space_s = (count_s == 2'd0) | pop_s;
`endif

  assign req_s       = (state_q == RUN) & space_s;
  assign xfer_s      = req_s & imem_ack;
  assign push_s      = xfer_s & ~branch_taken;
  assign push_data_s = {fetch_pc_q + PC_STEP, imem_rdata};

  // Sequencer and fetch PC; a redirect overrides everything, including a same-cycle transfer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      fetch_pc_q <= word_align(RESET_PC);
    end else if (branch_taken) begin
      state_q    <= REDIRECT;
      fetch_pc_q <= word_align(branch_addr);
    end else begin
      case (state_q)
        IDLE:     state_q <= RUN;
        RUN: begin
          if (xfer_s) begin
            fetch_pc_q <= fetch_pc_q + PC_STEP;
          end else begin
            fetch_pc_q <= fetch_pc_q;
          end
        end
        REDIRECT: state_q <= RUN;
        default:  state_q <= IDLE;
      endcase
    end
  end

  fetch_buffer u_buf (
    .clk     (clk),
    .rst     (rst),
    .push_i  (push_s),
    .pop_i   (pop_s),
    .clear_i (branch_taken),
    .data_i  (push_data_s),
    .head_o  (head_s),
    .count_o (count_s)
  );

  assign imem_req    = req_s;
  assign imem_addr   = fetch_pc_q;
  assign valid       = valid_s;
  assign instruction = head_s.instr;
  assign PC_out      = head_s.pc;

endmodule

// File: tb/tb_fetch_unit.sv
// Randomized self-checking bench for fetch_unit against a queue-based reference model.
module tb_fetch_unit;

`ifdef FETCH_PREFETCH_BUF_EN
  localparam int CAP = 2;
`else
  localparam int CAP = 1;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        hazard;
  logic        branch_taken;
  logic [31:0] branch_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        valid;
  logic [31:0] instruction;
  logic [31:0] PC_out;

  logic        req2;
  logic [31:0] addr2;
  logic        valid2;
  logic [31:0] instr2;
  logic [31:0] pc_out2;

  int n_checks = 0;
  int n_errors = 0;

  logic [63:0] mq[$];
  logic [31:0] m_pc;
  int          m_bubble;
  logic [31:0] m2_pc;
  int          m2_bubble;

  always #5 clk = ~clk;

  fetch_unit dut (
    .clk          (clk),
    .rst          (rst),
    .hazard       (hazard),
    .branch_taken (branch_taken),
    .branch_addr  (branch_addr),
    .imem_req     (imem_req),
    .imem_addr    (imem_addr),
    .imem_ack     (imem_ack),
    .imem_rdata   (imem_rdata),
    .valid        (valid),
    .instruction  (instruction),
    .PC_out       (PC_out)
  );

  fetch_unit #(.RESET_PC(32'hFFFF_FFF8)) dut_wrap (
    .clk          (clk),
    .rst          (rst),
    .hazard       (1'b0),
    .branch_taken (1'b0),
    .branch_addr  (32'h0000_0000),
    .imem_req     (req2),
    .imem_addr    (addr2),
    .imem_ack     (1'b1),
    .imem_rdata   (32'hA5A5_0000),
    .valid        (valid2),
    .instruction  (instr2),
    .PC_out       (pc_out2)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    m_pc      = 32'h0000_0000;
    m_bubble  = 1;
    m2_pc     = 32'hFFFF_FFF8;
    m2_bubble = 1;
  endtask

  task automatic check_reset_outputs();
    check_eq("rst_valid", {31'h0, valid}, 32'h0);
    check_eq("rst_instruction", instruction, 32'h0);
    check_eq("rst_PC_out", PC_out, 32'h0);
    check_eq("rst_imem_req", {31'h0, imem_req}, 32'h0);
    check_eq("rst_imem_addr", imem_addr, 32'h0000_0000);
    check_eq("rst_wrap_addr", addr2, 32'hFFFF_FFF8);
    check_eq("rst_wrap_valid", {31'h0, valid2}, 32'h0);
  endtask

  // One cycle: drive after the falling edge, check, advance the model, wait for next falling edge.
  task automatic step(input bit hz, input bit br, input logic [31:0] ba, input bit ack);
    bit          pop;
    bit          ereq;
    logic [63:0] head;
    hazard       = hz;
    branch_taken = br;
    branch_addr  = ba;
    imem_ack     = ack;
    imem_rdata   = $urandom;
    #1;
    pop  = (mq.size() > 0) && !hz;
    ereq = (m_bubble == 0) && ((mq.size() < CAP) || (CAP == 1 && pop));
    head = (mq.size() > 0) ? mq[0] : 64'h0;
    check_eq("imem_req", {31'h0, imem_req}, {31'h0, ereq});
    check_eq("imem_addr", imem_addr, m_pc);
    check_eq("valid", {31'h0, valid}, {31'h0, (mq.size() > 0)});
    check_eq("instruction", instruction, head[31:0]);
    check_eq("PC_out", PC_out, head[63:32]);
    check_eq("wrap_req", {31'h0, req2}, {31'h0, (m2_bubble == 0)});
    check_eq("wrap_addr", addr2, m2_pc);
    if (br) begin
      mq.delete();
      m_pc     = {ba[31:2], 2'b00};
      m_bubble = 1;
    end else begin
      if (pop) void'(mq.pop_front());
      if (ereq && ack) begin
        mq.push_back({m_pc + 32'd4, imem_rdata});
        m_pc = m_pc + 32'd4;
      end
      if (m_bubble > 0) m_bubble--;
    end
    if (m2_bubble > 0) m2_bubble = 0;
    else m2_pc = m2_pc + 32'd4;
    @(negedge clk);
  endtask

  initial begin
    rst          = 1'b1;
    hazard       = 1'b0;
    branch_taken = 1'b0;
    branch_addr  = 32'h0;
    imem_ack     = 1'b0;
    imem_rdata   = 32'h0;
    #1;
    check_reset_outputs();
    @(negedge clk);
    rst = 1'b0;
    model_reset();

    // Straight-line streaming, then hazard hold and resume.
    repeat (8) step(1'b0, 1'b0, 32'h0, 1'b1);
    repeat (3) step(1'b1, 1'b0, 32'h0, 1'b1);
    repeat (3) step(1'b0, 1'b0, 32'h0, 1'b1);

    // Redirect during a transfer (low address bits must be dropped), then redirect corner cases.
    step(1'b0, 1'b1, 32'h0000_0103, 1'b1);
    repeat (4) step(1'b0, 1'b0, 32'h0, 1'b1);
    step(1'b1, 1'b1, 32'h0000_0200, 1'b1);
    step(1'b0, 1'b1, 32'h0000_0300, 1'b1);
    repeat (3) step(1'b0, 1'b0, 32'h0, 1'b1);

    // Memory stall then recovery.
    repeat (4) step(1'b0, 1'b0, 32'h0, 1'b0);
    repeat (3) step(1'b0, 1'b0, 32'h0, 1'b1);

    // Redirect near the top of the address space to exercise wrap-around.
    step(1'b0, 1'b1, 32'hFFFF_FFF4, 1'b1);
    repeat (5) step(1'b0, 1'b0, 32'h0, 1'b1);

    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(0, 9) < 3), ($urandom_range(0, 19) == 0), $urandom,
           ($urandom_range(0, 9) < 7));
    end

    // Fill the buffer, then assert reset between clock edges.
    repeat (3) step(1'b0, 1'b0, 32'h0, 1'b1);
    repeat (3) step(1'b1, 1'b0, 32'h0, 1'b1);
    rst = 1'b1;
    #1;
    check_reset_outputs();
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    repeat (10) step(1'b0, 1'b0, 32'h0, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
